// File: rtl/phase_discriminator.sv
// Phase discriminator: differentiates CORDIC angles into per-sample phase deltas,
// squelches low-magnitude samples and averages 2^DECIM_LOG2 deltas per output.
module phase_discriminator #(
    parameter int unsigned DECIM_LOG2 = 3,
    parameter int unsigned W          = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic signed [W-1:0] ang_in,
    input  logic signed [W-1:0] mag_in,
    input  logic        [W-2:0] squelch_thr,
    input  logic                clear,
    output logic signed [W-1:0] freq_out,
    output logic                out_valid,
    output logic                squelch_out
);

    localparam int unsigned AW = W + DECIM_LOG2;
    localparam int unsigned CW = (DECIM_LOG2 == 0) ? 1 : DECIM_LOG2;
    localparam int unsigned SW = DECIM_LOG2 + 1;
    localparam int unsigned N  = 1 << DECIM_LOG2;

    typedef enum logic {PRIME, RUN} state_t;

    state_t               state_q, state_d;
    logic signed [W-1:0]  prev_ang_q, prev_ang_d;
    logic signed [AW-1:0] acc_q, acc_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [SW-1:0]        sq_cnt_q, sq_cnt_d;
    logic signed [W-1:0]  freq_q, freq_d;
    logic                 out_valid_q, out_valid_d;
    logic                 squelch_q, squelch_d;

    logic [W-2:0]         mag_eff;
    logic                 squelched;
    logic signed [W-1:0]  delta;
    logic signed [AW-1:0] sum;
    logic [SW-1:0]        sq_next;
    logic                 last;

    always_comb begin
        mag_eff   = mag_in[W-1] ? '0 : mag_in[W-2:0];
        squelched = (mag_eff < squelch_thr);
        // W-bit subtraction wraps modulo 2^W, matching the circular angle scale
        delta     = squelched ? '0 : (ang_in - prev_ang_q);
        sum       = acc_q + AW'(delta);
        sq_next   = sq_cnt_q + SW'(squelched);
        last      = (cnt_q == CW'(N - 1));
    end

    always_comb begin
        state_d     = state_q;
        prev_ang_d  = prev_ang_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        sq_cnt_d    = sq_cnt_q;
        freq_d      = freq_q;
        squelch_d   = squelch_q;
        out_valid_d = 1'b0;

        if (clear) begin
            state_d  = PRIME;
            acc_d    = '0;
            cnt_d    = '0;
            sq_cnt_d = '0;
        end else if (in_valid) begin
            prev_ang_d = ang_in;
            case (state_q)
                PRIME: state_d = RUN;
                RUN: begin
                    if (last) begin
                        freq_d      = sum[AW-1:DECIM_LOG2];
                        squelch_d   = (sq_next == SW'(N));
                        out_valid_d = 1'b1;
                        acc_d       = '0;
                        cnt_d       = '0;
                        sq_cnt_d    = '0;
                    end else begin
                        acc_d    = sum;
                        cnt_d    = cnt_q + CW'(1);
                        sq_cnt_d = sq_next;
                    end
                end
                default: state_d = PRIME;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= PRIME;
            prev_ang_q  <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            sq_cnt_q    <= '0;
            freq_q      <= '0;
            out_valid_q <= 1'b0;
            squelch_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_ang_q  <= prev_ang_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            sq_cnt_q    <= sq_cnt_d;
            freq_q      <= freq_d;
            out_valid_q <= out_valid_d;
            squelch_q   <= squelch_d;
        end
    end

    assign freq_out    = freq_q;
    assign out_valid   = out_valid_q;
    assign squelch_out = squelch_q;

endmodule

// File: tb/tb_phase_discriminator.sv
// Randomized and directed bench for phase_discriminator against a block-averaging
// reference model built from wrapped integer deltas and floor division.
module tb_phase_discriminator;

    localparam int DL = 3;
    localparam int W  = 16;
    localparam int NB = 1 << DL;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                in_valid;
    logic signed [W-1:0] ang_in;
    logic signed [W-1:0] mag_in;
    logic        [W-2:0] squelch_thr;
    logic                clear;
    logic signed [W-1:0] freq_out;
    logic                out_valid;
    logic                squelch_out;

    phase_discriminator #(.DECIM_LOG2(DL), .W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .ang_in     (ang_in),
        .mag_in     (mag_in),
        .squelch_thr(squelch_thr),
        .clear      (clear),
        .freq_out   (freq_out),
        .out_valid  (out_valid),
        .squelch_out(squelch_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model state
    bit m_primed = 0;
    int m_prev   = 0;
    int m_deltas[$];
    int m_sq     = 0;
    int e_freq   = 0;
    int e_sq     = 0;
    int e_ov     = 0;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int wrap_delta(input int a, input int b);
        int d;
        d = (a - b) % 65536;
        if (d < 0) d += 65536;
        if (d >= 32768) d -= 65536;
        return d;
    endfunction

    function automatic int floor_div(input int s, input int n);
        int q;
        q = s / n;
        if ((s % n != 0) && (s < 0)) q -= 1;
        return q;
    endfunction

    task automatic model(input bit v, input int ang, input int mag, input int thr,
                         input bit clr, input bit rn);
        int d, s, me;
        e_ov = 0;
        if (!rn) begin
            m_primed = 0; m_prev = 0; m_deltas.delete(); m_sq = 0;
            e_freq = 0; e_sq = 0;
        end else if (clr) begin
            m_primed = 0; m_deltas.delete(); m_sq = 0;
        end else if (v) begin
            if (!m_primed) begin
                m_primed = 1;
            end else begin
                me = (mag < 0) ? 0 : mag;
                d  = wrap_delta(ang, m_prev);
                if (me < thr) begin
                    d = 0;
                    m_sq++;
                end
                m_deltas.push_back(d);
                if (m_deltas.size() == NB) begin
                    s = 0;
                    foreach (m_deltas[k]) s += m_deltas[k];
                    e_freq = floor_div(s, NB);
                    e_sq   = (m_sq == NB) ? 1 : 0;
                    e_ov   = 1;
                    m_deltas.delete();
                    m_sq = 0;
                end
            end
            m_prev = ang;
        end
    endtask

    task automatic step(input bit v, input int ang, input int mag, input int thr,
                        input bit clr, input bit rn);
        @(negedge clk);
        in_valid    = v;
        ang_in      = W'(ang);
        mag_in      = W'(mag);
        squelch_thr = (W-1)'(thr);
        clear       = clr;
        rst_n       = rn;
        @(posedge clk);
        model(v, $signed(W'(ang)), $signed(W'(mag)), thr, clr, rn);
        #1;
        check("out_valid", int'(out_valid), e_ov);
        check("freq_out", int'(freq_out), e_freq);
        check("squelch_out", int'(squelch_out), e_sq);
    endtask

    task automatic do_reset();
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        int a;
        do_reset();
        check("reset_freq", int'(freq_out), 0);
        check("reset_ov", int'(out_valid), 0);

        // ramp +100: first output one cycle after the 9th sample
        for (int i = 0; i < 25; i++) begin
            step(1, i * 100, 1000, 10, 0, 1);
            if (i == 8) begin
                check("ramp_first_ov", int'(out_valid), 1);
                check("ramp_first_freq", int'(freq_out), 100);
                check("ramp_first_sq", int'(squelch_out), 0);
            end
        end

        // wrap across +pi, then -256 ramp
        do_reset();
        for (int i = 0; i < 18; i++) step(1, 32500 + i * 100, 1000, 10, 0, 1);
        check("wrap_freq", int'(freq_out), 100);
        do_reset();
        for (int i = 0; i < 9; i++) step(1, 1000 - i * 256, 1000, 10, 0, 1);
        check("neg_ramp_freq", int'(freq_out), -256);

        // full squelch, then half squelch
        do_reset();
        for (int i = 0; i < 9; i++) step(1, i * 100, 5, 10, 0, 1);
        check("squelch_all_freq", int'(freq_out), 0);
        check("squelch_all_flag", int'(squelch_out), 1);
        do_reset();
        for (int i = 0; i < 9; i++) step(1, i * 100, (i >= 1 && i <= 4) ? 5 : 1000, 10, 0, 1);
        check("squelch_half_freq", int'(freq_out), 50);
        check("squelch_half_flag", int'(squelch_out), 0);

        // negative magnitude counts as zero
        do_reset();
        for (int i = 0; i < 9; i++) step(1, i * 77, -3000, 1, 0, 1);

        // gaps, and floor rounding of seven 0s and one -1
        do_reset();
        for (int i = 0; i < 18; i++) begin
            step(1, i * 100, 1000, 10, 0, 1);
            step(0, 12345, 0, 0, 0, 1);
        end
        do_reset();
        for (int i = 0; i < 9; i++) step(1, (i == 8) ? 499 : 500, 1000, 10, 0, 1);
        check("floor_freq", int'(freq_out), -1);

        // clear coincident with in_valid after 4 deltas
        do_reset();
        for (int i = 0; i < 5; i++) step(1, i * 100, 1000, 10, 0, 1);
        step(1, 500, 1000, 10, 1, 1);
        check("clear_no_ov", int'(out_valid), 0);
        for (int i = 0; i < 9; i++) step(1, 600 + i * 30, 1000, 10, 0, 1);
        check("clear_refill_freq", int'(freq_out), 30);

        // reset mid-block then restart as the ramp
        for (int i = 0; i < 5; i++) step(1, i * 100, 1000, 10, 0, 1);
        step(1, 0, 1000, 10, 0, 0);
        check("midrst_freq", int'(freq_out), 0);
        for (int i = 0; i < 9; i++) step(1, i * 100, 1000, 10, 0, 1);
        check("midrst_restart", int'(freq_out), 100);

        // randomized traffic
        a = 0;
        for (int i = 0; i < 1500; i++) begin
            bit v, clr, rn;
            int r;
            r   = int'($urandom_range(0, 99));
            rn  = (r != 0);
            clr = (r == 1 || r == 2);
            v   = ($urandom_range(0, 3) != 0);
            a   = a + int'($urandom_range(0, 4000)) - 2000;
            if ($urandom_range(0, 19) == 0) a = int'($urandom_range(0, 65535));
            step(v, a, int'($urandom_range(0, 65535)) - 32768 + 32768 * int'($urandom_range(0, 1)) / 2,
                 int'($urandom_range(0, 20000)), clr, rn);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/phase_discriminator.md
PHASE_DISCRIMINATOR -- requirements
Module: phase_discriminator

Interface
REQ-001 The block SHALL have parameter DECIM_LOG2, default 3, giving the number of deltas averaged per output as 2^DECIM_LOG2; legal range is 0..8.
REQ-002 The block SHALL have parameter W, default 16, giving the angle and magnitude width in bits.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port in_valid, input, 1 bit: ang_in and mag_in are valid this cycle. It is driven by the CORDIC (vector mode) valid pipeline.
REQ-006 The block SHALL have port ang_in, input, W bits signed: the angle from CORDIC z_out. Full scale 2^W = 2*pi, so wrap is modular.
REQ-007 The block SHALL have port mag_in, input, W bits signed: the magnitude from CORDIC x_out. A negative value is treated as 0.
REQ-008 The block SHALL have port squelch_thr, input, W-1 bits unsigned: the magnitude threshold. It is sampled each in_valid cycle.
REQ-009 The block SHALL have port clear, input, 1 bit: a synchronous soft restart.
REQ-010 The block SHALL have port freq_out, output, W bits signed: the averaged phase delta per sample.
REQ-011 The block SHALL have port out_valid, output, 1 bit: a one-cycle strobe marking freq_out and squelch_out as new.
REQ-012 The block SHALL have port squelch_out, output, 1 bit: set to 1 when every delta in the block was squelched.

Function
REQ-013 The block SHALL implement a two-state FSM with states PRIME and RUN; PRIME is the reset state.
REQ-014 In PRIME, an in_valid cycle SHALL store ang_in in prev_ang, move to RUN, and produce no delta.
REQ-015 In RUN, on each in_valid cycle, the block SHALL compute delta = ang_in - prev_ang modulo 2^W, interpreted as signed W bits. Wrap example: 32700 -> -32736 gives delta +100.
REQ-016 In RUN, if the effective magnitude is less than squelch_thr, delta SHALL be forced to 0 and the per-block squelch count SHALL increment.
REQ-017 prev_ang SHALL update to ang_in on every in_valid cycle in RUN, whether or not the delta was squelched.
REQ-018 The accumulator SHALL be W+DECIM_LOG2 bits signed, SHALL add the sign-extended delta, and SHALL never saturate or overflow.
REQ-019 The delta counter (0..2^DECIM_LOG2-1) SHALL increment on each RUN in_valid cycle.
REQ-020 When the counter is at 2^DECIM_LOG2-1 and in_valid is 1, on the next rising edge the block SHALL:
- set freq_out = (acc + delta) >>> DECIM_LOG2, arithmetic shift, truncating toward minus infinity;
- pulse out_valid = 1 for exactly one cycle;
- set squelch_out = 1 if all 2^DECIM_LOG2 deltas were squelched, else 0;
- clear acc, the counter and the squelch count to 0.
REQ-021 Latency SHALL be 1 clock from the in_valid cycle carrying the last delta of a block to out_valid.
REQ-022 The first out_valid after PRIME SHALL follow the (2^DECIM_LOG2 + 1)-th valid sample.
REQ-023 When in_valid is 0, the block SHALL hold all state and SHALL drive out_valid to 0. Gaps of any length are legal.
REQ-024 freq_out and squelch_out SHALL hold their last values between out_valid pulses.
REQ-025 When clear is 1, on the next edge the block SHALL go to PRIME, zero acc, the counter and the squelch count, and drive out_valid to 0. freq_out and squelch_out hold their values.
REQ-026 clear SHALL have priority over a simultaneous in_valid; that sample is discarded.
REQ-027 When DECIM_LOG2 = 0, every RUN in_valid cycle SHALL produce an output, freq_out = delta.

Reset
REQ-028 When rst_n is 0 at a rising edge, the block SHALL set state = PRIME and zero prev_ang, acc, the counter, the squelch count, freq_out, out_valid and squelch_out.
REQ-029 Reset SHALL have priority over clear and over in_valid.
REQ-030 When reset is applied mid-block, the partial accumulation SHALL be discarded and no out_valid SHALL follow.
REQ-031 rst_n SHALL have no asynchronous effect.

Verification
REQ-032 Ramp test: DECIM_LOG2=3, continuous in_valid, ang_in = 0,100,200,... (+100 per sample), mag_in=1000, squelch_thr=10 -> first out_valid 1 cycle after the 9th sample with freq_out=100, squelch_out=0, then one output every 8 samples.
REQ-033 Wrap test: ang_in = 32500,32600,32700,-32736,-32636,... (step +100 across +pi) -> freq_out=100 with no discontinuity. A -256 step ramp -> freq_out=-256.
REQ-034 Squelch test: mag_in=5, squelch_thr=10 for a whole block -> freq_out=0, squelch_out=1. Half of the block squelched with step 100 -> freq_out=50, squelch_out=0.
REQ-035 Gap and rounding test: in_valid toggling 1/0 -> results identical to the continuous case. Deltas of seven 0s and one -1 -> freq_out=-1 (floor).
REQ-036 Clear test: clear after 4 deltas of a block, coincident with in_valid -> no out_valid; the next output requires 9 fresh samples. An out_valid in the same cycle as clear is not allowed.
REQ-037 Reset test: rst_n=0 for 1 cycle mid-block -> all outputs 0 next cycle, state PRIME; restart behaves exactly as in the ramp test.
